// File: rtl/conv_output_buffer_if.sv
// Stream boundary of the output buffer: valid-only sample input with prog_full back to the source,
// and a ready/valid/last master output towards the consumer.
interface conv_output_buffer_if #(
    parameter int DATA_W = 22
);
    logic              i_data_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_prog_full;
    logic              o_data_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_data_last;
    logic              i_data_ready;

    // Buffer side of the boundary.
    modport slave (
        input  i_data_valid,
        input  i_data,
        output o_prog_full,
        output o_data_valid,
        output o_data,
        output o_data_last,
        input  i_data_ready
    );

    // Environment side: drives the sample stream and the consumer ready.
    modport master (
        output i_data_valid,
        output i_data,
        input  o_prog_full,
        input  o_data_valid,
        input  o_data,
        input  o_data_last,
        output i_data_ready
    );
endinterface

// File: rtl/conv_output_buffer.sv
// FWFT FIFO turning an unstallable sample stream into a ready/valid master with per-frame last.
// Write visible the cycle after the push edge; drops (and flags overflow) when full; prog_full throttles upstream.
module conv_output_buffer #(
    parameter int DATA_W           = 22,
    parameter int DEPTH            = 32,
    parameter int PROG_FULL_THRESH = 24,
    parameter int FRAME_BEATS      = 512
) (
    input  logic                   axi_clk,
    input  logic                   axi_reset_n,
    conv_output_buffer_if.slave    bus,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow,
    output logic                   o_frame_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] PF_LEVEL   = LW'(PROG_FULL_THRESH);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(FRAME_BEATS - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic [BW-1:0]     beat_cnt;
    logic              overflow;
    logic              frame_done;

    logic full;
    logic data_valid;
    logic data_last;
    logic push;
    logic pop;

    // Full/empty come from the level count only; pointers wrap freely.
    assign full       = (level == FULL_LEVEL);
    assign data_valid = (level != '0);
    assign data_last  = data_valid && (beat_cnt == LAST_BEAT);
    assign push       = bus.i_data_valid && !full;
    assign pop        = data_valid && bus.i_data_ready;

    assign bus.o_data_valid = data_valid;
    assign bus.o_data       = mem[rd_ptr];
    assign bus.o_data_last  = data_last;
    assign bus.o_prog_full  = (level >= PF_LEVEL);

    assign o_level      = level;
    assign o_overflow   = overflow;
    assign o_frame_done = frame_done;

    // Storage is deliberately not reset.
    always_ff @(posedge axi_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.i_data;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            beat_cnt   <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end

            if (pop) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
            end

            if (bus.i_data_valid && full) begin
                overflow <= 1'b1;
            end

            frame_done <= pop && data_last;
        end
    end
endmodule

// File: tb/tb_conv_output_buffer.sv
// Directed table plus randomized traffic for conv_output_buffer, checked against a queue-based model.
module tb_conv_output_buffer;
    localparam int DW    = 22;
    localparam int DEPTH = 32;
    localparam int PFT   = 24;
    localparam int FB    = 4;

    logic          clk;
    logic          axi_reset_n;
    logic [5:0]    o_level;
    logic          o_overflow;
    logic          o_frame_done;

    conv_output_buffer_if #(.DATA_W(DW)) bus ();

    conv_output_buffer #(
        .DATA_W          (DW),
        .DEPTH           (DEPTH),
        .PROG_FULL_THRESH(PFT),
        .FRAME_BEATS     (FB)
    ) dut (
        .axi_clk     (clk),
        .axi_reset_n (axi_reset_n),
        .bus         (bus.slave),
        .o_level     (o_level),
        .o_overflow  (o_overflow),
        .o_frame_done(o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: contents as a queue, beats counted per frame.
    logic [DW-1:0] q[$];
    int            m_beat = 0;
    bit            m_ovf  = 1'b0;
    bit            m_fd   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst_n, input bit vld, input logic [DW-1:0] dat, input bit rdy);
        bit pop_now;
        bit last_now;
        if (!rst_n) begin
            q.delete();
            m_beat = 0;
            m_ovf  = 1'b0;
            m_fd   = 1'b0;
        end else begin
            pop_now  = (q.size() != 0) && rdy;
            last_now = pop_now && (m_beat == FB - 1);
            if (vld && q.size() == DEPTH) m_ovf = 1'b1;
            if (pop_now) begin
                void'(q.pop_front());
                m_beat = (m_beat + 1) % FB;
            end
            if (vld && (q.size() + (pop_now ? 1 : 0)) != DEPTH) q.push_back(dat);
            m_fd = last_now;
        end
    endtask

    task automatic compare_model();
        chk("level", 32'(o_level), 32'(q.size()));
        chk("valid", 32'(bus.o_data_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("data", 32'(bus.o_data), 32'(q[0]));
        chk("last", 32'(bus.o_data_last), 32'((q.size() != 0) && (m_beat == FB - 1)));
        chk("prog_full", 32'(bus.o_prog_full), 32'(q.size() >= PFT));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("frame_done", 32'(o_frame_done), 32'(m_fd));
    endtask

    // Inputs held across one rising edge; outputs sampled 1 time unit later.
    task automatic tick(input bit rst_n, input bit vld, input logic [DW-1:0] dat, input bit rdy);
        axi_reset_n      = rst_n;
        bus.i_data_valid = vld;
        bus.i_data       = dat;
        bus.i_data_ready = rdy;
        @(posedge clk);
        model_step(rst_n, vld, dat, rdy);
        #1;
        compare_model();
    endtask

    typedef struct {
        bit            rst_n;
        bit            vld;
        logic [DW-1:0] dat;
        bit            rdy;
        int            lvl;
        bit            evld;
        logic [DW-1:0] edat;
        bit            elast;
        bit            efd;
    } tv_t;

    tv_t tbl[19];

    initial begin
        int lastmask;
        int fdcnt;
        int bidx;

        axi_reset_n      = 1'b0;
        bus.i_data_valid = 1'b0;
        bus.i_data       = '0;
        bus.i_data_ready = 1'b0;

        // In-order FWFT drain, frame last on beat 3, then push+pop at level 1.
        tbl[0]  = '{0, 0, 22'h0,  0, 0, 0, 22'h0, 0, 0};
        tbl[1]  = '{1, 1, 22'h1,  0, 1, 1, 22'h1, 0, 0};
        tbl[2]  = '{1, 1, 22'h2,  0, 2, 1, 22'h1, 0, 0};
        tbl[3]  = '{1, 1, 22'h3,  0, 3, 1, 22'h1, 0, 0};
        tbl[4]  = '{1, 1, 22'h4,  0, 4, 1, 22'h1, 0, 0};
        tbl[5]  = '{1, 1, 22'h5,  0, 5, 1, 22'h1, 0, 0};
        tbl[6]  = '{1, 0, 22'h0,  0, 5, 1, 22'h1, 0, 0};
        tbl[7]  = '{1, 0, 22'h0,  1, 4, 1, 22'h2, 0, 0};
        tbl[8]  = '{1, 0, 22'h0,  1, 3, 1, 22'h3, 0, 0};
        tbl[9]  = '{1, 0, 22'h0,  1, 2, 1, 22'h4, 1, 0};
        tbl[10] = '{1, 0, 22'h0,  1, 1, 1, 22'h5, 0, 1};
        tbl[11] = '{1, 0, 22'h0,  1, 0, 0, 22'h0, 0, 0};
        tbl[12] = '{1, 0, 22'h0,  1, 0, 0, 22'h0, 0, 0};
        tbl[13] = '{1, 1, 22'hA,  1, 1, 1, 22'hA, 0, 0};
        tbl[14] = '{1, 1, 22'hB,  1, 1, 1, 22'hB, 0, 0};
        tbl[15] = '{1, 1, 22'hC,  1, 1, 1, 22'hC, 1, 0};
        tbl[16] = '{1, 0, 22'h0,  0, 1, 1, 22'hC, 1, 0};
        tbl[17] = '{1, 0, 22'h0,  1, 0, 0, 22'h0, 0, 1};
        tbl[18] = '{1, 0, 22'h0,  0, 0, 0, 22'h0, 0, 0};

        for (int i = 0; i < 19; i++) begin
            tick(tbl[i].rst_n, tbl[i].vld, tbl[i].dat, tbl[i].rdy);
            chk($sformatf("tbl%0d_level", i), 32'(o_level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.o_data_valid), 32'(tbl[i].evld));
            if (tbl[i].evld) chk($sformatf("tbl%0d_data", i), 32'(bus.o_data), 32'(tbl[i].edat));
            chk($sformatf("tbl%0d_last", i), 32'(bus.o_data_last), 32'(tbl[i].elast));
            chk($sformatf("tbl%0d_fdone", i), 32'(o_frame_done), 32'(tbl[i].efd));
        end

        // prog_full threshold crossing in both directions.
        tick(0, 0, 0, 0);
        for (int i = 0; i < PFT; i++) begin
            tick(1, 1, DW'(i + 100), 0);
            chk("pf_rise", 32'(bus.o_prog_full), 32'(i == PFT - 1));
        end
        tick(1, 0, 0, 1);
        chk("pf_fall_level", 32'(o_level), 32'(PFT - 1));
        chk("pf_fall", 32'(bus.o_prog_full), 32'(0));

        // Overflow: 33 writes into 32 entries, then a write racing a pop while full.
        tick(0, 0, 0, 0);
        for (int i = 0; i <= DEPTH; i++) tick(1, 1, DW'(i), 0);
        chk("ovf_level", 32'(o_level), 32'(DEPTH));
        chk("ovf_flag", 32'(o_overflow), 32'(1));
        tick(1, 1, 22'h3FFFFF, 1);
        chk("full_pop_level", 32'(o_level), 32'(DEPTH - 1));
        for (int i = 1; i < DEPTH; i++) begin
            chk("drain_data", 32'(bus.o_data), 32'(i));
            tick(1, 0, 0, 1);
        end
        chk("drain_empty", 32'(bus.o_data_valid), 32'(0));
        chk("ovf_sticky", 32'(o_overflow), 32'(1));

        // 10 samples streamed with ready high: last on beats 3 and 7 only.
        tick(0, 0, 0, 0);
        lastmask = 0;
        fdcnt    = 0;
        bidx     = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.o_data_valid) begin
                if (bus.o_data_last) lastmask |= (1 << bidx);
                bidx++;
            end
            tick(1, i < 10, DW'(i + 200), 1);
            if (o_frame_done) fdcnt++;
        end
        chk("frame_beats", 32'(bidx), 32'(10));
        chk("last_beats", 32'(lastmask), 32'h88);
        chk("fdone_count", 32'(fdcnt), 32'(2));
        tick(1, 1, 22'h11, 0);
        tick(1, 1, 22'h12, 0);
        chk("beat2_not_last", 32'(bus.o_data_last), 32'(0));
        tick(1, 0, 0, 1);
        chk("beat3_last", 32'(bus.o_data_last), 32'(1));

        // Mid-frame reset: level 10, beat 2, then restart counting from 0.
        tick(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick(1, 1, DW'(i + 300), 0);
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        chk("pre_rst_level", 32'(o_level), 32'(10));
        tick(0, 1, 22'h55, 1);
        chk("rst_level", 32'(o_level), 32'(0));
        chk("rst_valid", 32'(bus.o_data_valid), 32'(0));
        chk("rst_ovf", 32'(o_overflow), 32'(0));
        chk("rst_pf", 32'(bus.o_prog_full), 32'(0));
        for (int i = 0; i < FB; i++) tick(1, 1, DW'(i + 400), 0);
        for (int i = 0; i < FB; i++) begin
            chk("post_rst_last", 32'(bus.o_data_last), 32'(i == FB - 1));
            tick(1, 0, 0, 1);
        end

        // Random traffic with shifting backpressure and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            int rpct;
            case ((i / 500) % 4)
                0:       rpct = 90;
                1:       rpct = 30;
                2:       rpct = 60;
                default: rpct = 10;
            endcase
            tick($urandom_range(0, 299) != 0,
                 $urandom_range(0, 99) < 75,
                 DW'($urandom),
                 $urandom_range(0, 99) < rpct);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv_output_buffer.md
Name: conv_output_buffer

Overview:
- Output stage directly downstream of the image-processing top level.
- Takes the 22-bit convolved result stream, which has valid only and cannot be stalled, and buffers it in a synchronous first-word-fall-through FIFO.
- Presents it as an AXI-Stream-style master with ready/valid backpressure and a per-frame TLAST.
- Drives the programmable-full flag that becomes the upstream slave ready (o_data_ready = !prog_full).

Parameters:
- DATA_W, 22, width of a convolved sample.
- DEPTH, 32, FIFO entries; power of two, ≥4.
- PROG_FULL_THRESH, 24, occupancy at or above which prog_full asserts; 1 ≤ value ≤ DEPTH.
- FRAME_BEATS, 512, output beats per frame; last one carries o_data_last; ≥1.

Ports:
- axi_clk  in  1  single clock, all logic rising-edge.
- axi_reset_n  in  1  synchronous active-low reset.
- i_data_valid  in  1  convolved sample valid; source ignores backpressure.
- i_data  in  DATA_W  convolved sample.
- o_prog_full  out  1  occupancy ≥ PROG_FULL_THRESH; top level inverts it to drive slave ready.
- o_data_valid  out  1  master valid.
- o_data  out  DATA_W  master data, the head of the FIFO.
- o_data_last  out  1  master last; marks beat FRAME_BEATS-1 of each frame.
- i_data_ready  in  1  master ready from the consumer.
- o_level  out  clog2(DEPTH)+1  current occupancy.
- o_overflow  out  1  sticky: a sample arrived while full and was dropped.
- o_frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted.

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of axi_clk.
  - Pointers, level, beat counter, o_overflow and o_frame_done go to 0.
  - Hence o_data_valid=0, o_data_last=0, o_prog_full=0.
  - o_data is don't-care while o_data_valid=0.
  - Reset mid-frame discards all contents and restarts the beat count at 0.
  - Memory contents are not cleared.
- Write: push = i_data_valid && (level != DEPTH).
  - Data is stored at wr_ptr; wr_ptr increments modulo DEPTH.
  - If i_data_valid && level==DEPTH, the sample is dropped and o_overflow is set. It stays set until reset.
  - A write is never accepted while full, even if a pop happens in the same cycle.
- Read (FWFT):
  - o_data_valid = (level != 0), o_data = mem[rd_ptr], both driven from registered state.
  - pop = o_data_valid && i_data_ready; rd_ptr increments modulo DEPTH.
  - o_data and o_data_last hold stable while valid && !ready.
- Latency: a sample written on edge N is visible with o_data_valid=1 after edge N. It can be popped on edge N+1 at the earliest.
- Level: push&&!pop → +1; pop&&!push → -1; both or neither → unchanged.
  - Simultaneous push and pop when level==1 keeps o_data_valid high, with new data.
  - Empty: pop is impossible and a push alone takes level to 1.
- o_prog_full = (level ≥ PROG_FULL_THRESH), from the registered level, so it updates one cycle after the causing push/pop.
- Beat counter: 0..FRAME_BEATS-1, increments on pop, wraps to 0 after the pop at FRAME_BEATS-1.
  - o_data_last = o_data_valid && (beat_cnt == FRAME_BEATS-1).
  - FRAME_BEATS=1 makes every beat last.
- o_frame_done is registered: high for exactly one cycle following a pop with o_data_last=1.
- Pointers are clog2(DEPTH) bits wide and wrap naturally. Full and empty come from level, not pointer compare.

Test Plan:
1. Reset, then write 5 samples 0x000001..0x000005 on consecutive cycles with i_data_ready=0 → level=5, o_data=0x000001 stable. Then ready=1 → samples out in order over 5 cycles, valid drops after the 5th, level=0.
2. DEPTH=32, PROG_FULL_THRESH=24, ready=0, write 24 samples → o_prog_full rises the cycle after the 24th write. One pop → it falls one cycle later at level=23.
3. Ready=0, write 33 samples (0..32) → level stays at 32, o_overflow=1, sample 32 dropped. Drain → exactly 0..31 read out; o_overflow remains 1 until reset.
4. FRAME_BEATS=4, write 10 samples with ready=1 → o_data_last on beats 3 and 7 only; o_frame_done pulses once, the cycle after each of those pops; beat count at end = 2.
5. Level=1, push and pop in the same cycle → level stays 1, o_data_valid stays 1, o_data becomes the new sample.
6. Mid-stream (level=10, beat_cnt=2) assert axi_reset_n=0 for one edge → next cycle level=0, o_data_valid=0, o_overflow=0, o_prog_full=0; the next frame's last appears on beat FRAME_BEATS-1 counted from 0.
